// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, panel output record and helpers for the LCD output stage.
// The colour-bar table is used only when LCD_TEST_PATTERN_EN is defined.
package lcd_timing_pkg;

    localparam int H_TOTAL_DEF  = 1056;
    localparam int H_SYNC_DEF   = 30;
    localparam int H_START_DEF  = 216;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_TOTAL_DEF  = 525;
    localparam int V_SYNC_DEF   = 13;
    localparam int V_START_DEF  = 35;
    localparam int V_ACTIVE_DEF = 480;

    localparam int H_W = 11;
    localparam int V_W = 10;

    // Test-pattern bars: 80 pixels each, {R,G,B} per bar, left to right.
    localparam int BAR_WIDTH = 80;
    localparam logic [23:0] BAR_RGB [0:7] = '{
        24'hFFFFFF,  // white
        24'hFFFF00,  // yellow
        24'h00FFFF,  // cyan
        24'h00FF00,  // green
        24'hFF00FF,  // magenta
        24'hFF0000,  // red
        24'h0000FF,  // blue
        24'h000000   // black
    };

    // Everything that leaves the panel output register except the pixel clock.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       den;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } panel_t;

    localparam panel_t PANEL_IDLE = '{hs: 1'b1, vs: 1'b1, den: 1'b0,
                                      r: 8'h00, g: 8'h00, b: 8'h00};

    // Inclusive unsigned window test. V values are zero-extended to H width,
    // which leaves the 10-bit comparison result unchanged.
    function automatic logic in_window(input logic [H_W-1:0] value,
                                       input logic [H_W-1:0] lo,
                                       input logic [H_W-1:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/lcd_timing_out_counter.sv
// Raster timebase: pixel-rate enable toggle, H/V position counters and the
// frame-start pulse. Counters advance only on edges where Clock_en is high.
module lcd_raster_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           Enable,
    output logic           Clock_en,
    output logic [H_W-1:0] H_Count,
    output logic [V_W-1:0] V_Count,
    output logic           Frame_start
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    // Enable toggle and position counters; Enable low clears like reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Clock_en <= 1'b0;
            H_Count  <= '0;
            V_Count  <= '0;
        end else if (!Enable) begin
            Clock_en <= 1'b0;
            H_Count  <= '0;
            V_Count  <= '0;
        end else begin
            Clock_en <= ~Clock_en;
            if (Clock_en) begin
                if (H_Count == H_LAST) begin
                    H_Count <= '0;
                    if (V_Count == V_LAST) begin
                        V_Count <= '0;
                    end else begin
                        V_Count <= V_Count + 1'b1;
                    end
                end else begin
                    H_Count <= H_Count + 1'b1;
                end
            end
        end
    end

    // Single Clock-wide pulse: the only cycle with Clock_en high at the origin.
    assign Frame_start = Enable & Clock_en & (H_Count == '0) & (V_Count == '0);

endmodule

// File: rtl/lcd_timing_out.sv
// LCD output stage: raster timing, read strobe into the filter output line
// buffer, and the registered panel interface (RGB, syncs, DEN, pixel clock).
// Optional build macro: LCD_TEST_PATTERN_EN adds Pattern_sel, which replaces
// the active-area pixel data with eight vertical colour bars.
module lcd_timing_out
    import lcd_timing_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_START  = H_START_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_START  = V_START_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        Clock_en,
    output logic [10:0] H_Count,
    output logic [9:0]  V_Count,
    output logic        oRead_out_en,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
`ifdef LCD_TEST_PATTERN_EN
    input  logic        Pattern_sel,
`endif
    output logic        oFrame_start,
    output logic        LCD_NCLK,
    output logic        LCD_HS,
    output logic        LCD_VS,
    output logic        LCD_DEN,
    output logic [7:0]  LCD_R,
    output logic [7:0]  LCD_G,
    output logic [7:0]  LCD_B
);

    // The read window opens one pixel early so buffer data is ready when the
    // output register samples the first active pixel.
    localparam logic [H_W-1:0] RD_H_LO  = H_W'(H_START - 1);
    localparam logic [H_W-1:0] RD_H_HI  = H_W'(H_START + H_ACTIVE - 2);
    localparam logic [H_W-1:0] DEN_H_LO = H_W'(H_START);
    localparam logic [H_W-1:0] DEN_H_HI = H_W'(H_START + H_ACTIVE - 1);
    localparam logic [H_W-1:0] ACT_V_LO = H_W'(V_START);
    localparam logic [H_W-1:0] ACT_V_HI = H_W'(V_START + V_ACTIVE - 1);
    localparam logic [H_W-1:0] HS_WIDTH = H_W'(H_SYNC);
    localparam logic [H_W-1:0] VS_WIDTH = H_W'(V_SYNC);

    logic [H_W-1:0] v_ext;
    logic           v_active;
    logic           den_win;
    logic [23:0]    pix_rgb;
    panel_t         panel_d;
    panel_t         panel_q;

    lcd_raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Enable      (Enable),
        .Clock_en    (Clock_en),
        .H_Count     (H_Count),
        .V_Count     (V_Count),
        .Frame_start (oFrame_start)
    );

    assign v_ext    = {1'b0, V_Count};
    assign v_active = in_window(v_ext, ACT_V_LO, ACT_V_HI);

    // One strobe per pixel period, H_ACTIVE of them on each active line.
    assign oRead_out_en = Enable & Clock_en & v_active &
                          in_window(H_Count, RD_H_LO, RD_H_HI);

`ifdef LCD_TEST_PATTERN_EN
    logic [H_W-1:0] h_off;
    logic [2:0]     bar_idx;

    // Colour-bar source selected by Pattern_sel; pipe data otherwise.
    always_comb begin
        h_off   = H_Count - DEN_H_LO;
        bar_idx = 3'(h_off / H_W'(BAR_WIDTH));
        pix_rgb = Pattern_sel ? BAR_RGB[bar_idx] : {R_in, G_in, B_in};
    end
`else
    assign pix_rgb = {R_in, G_in, B_in};
`endif

    // Next panel word from the pre-edge counters.
    always_comb begin
        panel_d     = PANEL_IDLE;
        den_win     = in_window(H_Count, DEN_H_LO, DEN_H_HI) & v_active;
        panel_d.hs  = ~(H_Count < HS_WIDTH);
        panel_d.vs  = ~(v_ext < VS_WIDTH);
        panel_d.den = den_win;
        if (den_win) begin
            panel_d.r = pix_rgb[23:16];
            panel_d.g = pix_rgb[15:8];
            panel_d.b = pix_rgb[7:0];
        end
    end

    // Panel register: data on Clock_en edges, NCLK tracks Clock_en so its
    // rising edge lands mid-pixel, one Clock after the data changes.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            LCD_NCLK <= 1'b0;
            panel_q  <= PANEL_IDLE;
        end else if (!Enable) begin
            LCD_NCLK <= 1'b0;
            panel_q  <= PANEL_IDLE;
        end else begin
            LCD_NCLK <= ~Clock_en;
            if (Clock_en) begin
                panel_q <= panel_d;
            end
        end
    end

    assign LCD_HS  = panel_q.hs;
    assign LCD_VS  = panel_q.vs;
    assign LCD_DEN = panel_q.den;
    assign LCD_R   = panel_q.r;
    assign LCD_G   = panel_q.g;
    assign LCD_B   = panel_q.b;

endmodule

// File: tb/tb_lcd_timing_out.sv
// Bench for lcd_timing_out: a full-size instance for line timing, read strobes
// and the pixel data path, plus a shrunken-raster instance for frame wrap,
// frame-start period and asynchronous reset.
module tb_lcd_timing_out;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- full-size DUT ----------------
  logic rstn_f = 1'b0, en_f = 1'b0;
  logic [7:0] r_f = 8'h00, g_f = 8'h00, b_f = 8'h00;
  logic ce_f, rd_f, fs_f, nclk_f, hs_f, vs_f, den_f;
  logic [10:0] h_f;
  logic [9:0] v_f;
  logic [7:0] lr_f, lg_f, lb_f;

  lcd_timing_out dut_full (
    .Clock(Clock), .Resetn(rstn_f), .Enable(en_f),
    .Clock_en(ce_f), .H_Count(h_f), .V_Count(v_f), .oRead_out_en(rd_f),
    .R_in(r_f), .G_in(g_f), .B_in(b_f),
`ifdef LCD_TEST_PATTERN_EN
    .Pattern_sel(1'b0),
`endif
    .oFrame_start(fs_f), .LCD_NCLK(nclk_f), .LCD_HS(hs_f), .LCD_VS(vs_f),
    .LCD_DEN(den_f), .LCD_R(lr_f), .LCD_G(lg_f), .LCD_B(lb_f)
  );

  // ---------------- small-raster DUT (24 x 8, frame = 384 Clocks) ----------------
  logic rstn_s = 1'b0, en_s = 1'b0;
  logic [7:0] r_s = 8'h5A, g_s = 8'hC3, b_s = 8'h0F;
  logic ce_s, rd_s, fs_s, nclk_s, hs_s, vs_s, den_s;
  logic [10:0] h_s;
  logic [9:0] v_s;
  logic [7:0] lr_s, lg_s, lb_s;

  lcd_timing_out #(
    .H_TOTAL(24), .H_SYNC(3), .H_START(6), .H_ACTIVE(12),
    .V_TOTAL(8), .V_SYNC(2), .V_START(2), .V_ACTIVE(4)
  ) dut_small (
    .Clock(Clock), .Resetn(rstn_s), .Enable(en_s),
    .Clock_en(ce_s), .H_Count(h_s), .V_Count(v_s), .oRead_out_en(rd_s),
    .R_in(r_s), .G_in(g_s), .B_in(b_s),
`ifdef LCD_TEST_PATTERN_EN
    .Pattern_sel(1'b0),
`endif
    .oFrame_start(fs_s), .LCD_NCLK(nclk_s), .LCD_HS(hs_s), .LCD_VS(vs_s),
    .LCD_DEN(den_s), .LCD_R(lr_s), .LCD_G(lg_s), .LCD_B(lb_s)
  );

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag, input logic ce, input logic [10:0] h,
                            input logic [9:0] v, input logic rd, input logic fs,
                            input logic nclk, input logic hs, input logic vs,
                            input logic den, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
    check({tag, ".clock_en"}, ce, 0);
    check({tag, ".h"}, h, 0);
    check({tag, ".v"}, v, 0);
    check({tag, ".read_en"}, rd, 0);
    check({tag, ".frame_start"}, fs, 0);
    check({tag, ".nclk"}, nclk, 0);
    check({tag, ".hs"}, hs, 1);
    check({tag, ".vs"}, vs, 1);
    check({tag, ".den"}, den, 0);
    check({tag, ".rgb"}, {r, g, b}, 0);
  endtask

  task automatic wait_full(input int h, input int v, input int budget);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(h_f == h && v_f == v) && n < budget);
    if (!(h_f == h && v_f == v)) begin
      checks++;
      errors++;
      $display("FAIL timeout_full waiting h=%0d v=%0d", h, v);
    end
  endtask

  task automatic wait_small(input int h, input int v, input int budget);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(h_s == h && v_s == v) && n < budget);
    if (!(h_s == h && v_s == v)) begin
      checks++;
      errors++;
      $display("FAIL timeout_small waiting h=%0d v=%0d", h, v);
    end
  endtask

  // ---------------- driver: strobe -> pixel data, expected value queued ----------------
  logic [23:0] exp_q[$];
  int data_cnt = 0;
  logic strobe_neg = 1'b0;
  logic drv_fire = 1'b0;

  always @(negedge Clock) strobe_neg = rd_f;

  // Buffer data appears one Clock after the strobe edge.
  initial begin
    forever begin
      @(posedge Clock);
      if (drv_fire) begin
        #1;
        r_f = data_cnt[7:0];
        g_f = ~data_cnt[7:0];
        b_f = data_cnt[7:0] ^ 8'h3C;
        exp_q.push_back({r_f, g_f, b_f});
        data_cnt++;
      end
      drv_fire = strobe_neg;
    end
  end

  // ---------------- monitor: one look per pixel, in its NCLK-high half ----------------
  int den_pix = 0;
  logic [23:0] exp_pix;

  always @(negedge Clock) begin
    if (rstn_f && nclk_f) begin
      if (den_f) begin
        den_pix++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_underflow actual=%0h required=queued_value", {lr_f, lg_f, lb_f});
        end else begin
          exp_pix = exp_q.pop_front();
          check("pixel_rgb", {lr_f, lg_f, lb_f}, exp_pix);
        end
      end else begin
        check("blank_rgb", {lr_f, lg_f, lb_f}, 0);
      end
    end
  end

  // Strobe statistics and DEN latency on the full instance.
  int str34 = 0, str35 = 0, first_h35 = -1, last_h35 = -1, t_h216 = -1, t_den = -1;
  always @(negedge Clock) begin
    if (rd_f && v_f == 10'd34) str34++;
    if (rd_f && v_f == 10'd35) begin
      str35++;
      if (first_h35 < 0) first_h35 = int'(h_f);
      last_h35 = int'(h_f);
    end
    if (v_f == 10'd35 && h_f == 11'd216 && t_h216 < 0) t_h216 = cyc;
    if (den_f && t_den < 0) t_den = cyc;
  end

  // Frame-start monitor on the small instance.
  logic fs_mon = 1'b0;
  int last_fs = -1, fs_cnt = 0;
  always @(negedge Clock) begin
    if (fs_mon && fs_s) begin
      check("fs_at_origin", {ce_s, h_s, v_s}, {1'b1, 11'd0, 10'd0});
      if (last_fs >= 0) check("fs_period", cyc - last_fs, 384);
      last_fs = cyc;
      fs_cnt++;
    end
  end

  // ---------------- full-size sequence ----------------
  task automatic run_full();
    int t_a;
    int hs_low;
    repeat (3) @(negedge Clock);
    check_idle("rst_full", ce_f, h_f, v_f, rd_f, fs_f, nclk_f, hs_f, vs_f, den_f, lr_f, lg_f, lb_f);
    rstn_f = 1'b1;
    en_f = 1'b1;

    // Line 0 wraps into line 1; then measure one full line.
    wait_full(1055, 0, 3000);
    for (int i = 0; i < 4 && h_f == 11'd1055; i++) @(negedge Clock);
    check("line_wrap_h", h_f, 0);
    check("line_wrap_v", v_f, 1);
    t_a = cyc;
    wait_full(0, 2, 5000);
    check("line_period", cyc - t_a, 2112);

    // Enable dropped mid-line for 10 Clocks.
    wait_full(300, 2, 2000);
    en_f = 1'b0;
    repeat (10) @(negedge Clock);
    check_idle("en_low", ce_f, h_f, v_f, rd_f, fs_f, nclk_f, hs_f, vs_f, den_f, lr_f, lg_f, lb_f);
    en_f = 1'b1;
    @(negedge Clock);
    check("restart_h", h_f, 0);
    check("restart_v", v_f, 0);
    check("restart_clock_en", ce_f, 1);
    check("restart_nclk", nclk_f, 1);
    check("restart_hs", hs_f, 1);
    hs_low = 0;
    for (int k = 1; k < 100; k++) begin
      @(negedge Clock);
      if (!hs_f) hs_low++;
      if (k == 5) check("restart_vs", vs_f, 0);
    end
    check("hs_low_clocks", hs_low, 60);

    // Run through the first active line.
    wait_full(0, 36, 80000);
    check("strobes_v34", str34, 0);
    check("strobes_v35", str35, 640);
    check("first_strobe_h", first_h35, 215);
    check("last_strobe_h", last_h35, 854);
    check("den_latency", t_den - t_h216, 2);
    check("den_pixels", den_pix, 640);
    check("data_issued", data_cnt, 640);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- small-raster sequence ----------------
  task automatic run_small();
    repeat (2) @(negedge Clock);
    check_idle("rst_small", ce_s, h_s, v_s, rd_s, fs_s, nclk_s, hs_s, vs_s, den_s, lr_s, lg_s, lb_s);
    rstn_s = 1'b1;
    en_s = 1'b1;

    // Frame wrap (23,7) -> (0,0).
    wait_small(23, 7, 500);
    for (int i = 0; i < 4 && h_s == 11'd23; i++) @(negedge Clock);
    check("frame_wrap_h", h_s, 0);
    check("frame_wrap_v", v_s, 0);

    // Three frame-start pulses, 384 Clocks apart.
    fs_mon = 1'b1;
    repeat (3 * 384 - 10) @(negedge Clock);
    fs_mon = 1'b0;
    check("fs_count", fs_cnt, 3);

    // First active pixel of the small raster carries the input data.
    wait_small(6, 2, 500);
    repeat (2) @(negedge Clock);
    check("small_den", den_s, 1);
    check("small_rgb", {lr_s, lg_s, lb_s}, 24'h5AC30F);

    // Asynchronous reset mid-frame takes effect before the next edge.
    wait_small(10, 5, 500);
    #2;
    rstn_s = 1'b0;
    #1;
    check_idle("async_rst", ce_s, h_s, v_s, rd_s, fs_s, nclk_s, hs_s, vs_s, den_s, lr_s, lg_s, lb_s);
    repeat (3) @(negedge Clock);
    rstn_s = 1'b1;
    @(negedge Clock);
    check("post_rst_h", h_s, 0);
    check("post_rst_v", v_s, 0);
    check("post_rst_clock_en", ce_s, 1);
    repeat (2) @(negedge Clock);
    check("post_rst_h_step", h_s, 1);
  endtask

  initial begin
    fork
      run_full();
      run_small();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
